// File: rtl/circle_raster_pkg.sv
// Shared definitions for the circle rasteriser: FSM state encoding, draw-mode
// constants and the default screen geometry.
package circle_raster_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    EMIT  = 3'd3,
    STEP  = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic MODE_OUTLINE = 1'b0;
  localparam logic MODE_FILL    = 1'b1;

  localparam int unsigned DEF_SCREEN_W = 640;
  localparam int unsigned DEF_SCREEN_H = 480;

endpackage : circle_raster_pkg

// File: rtl/circle_clip.sv
// Combinational screen clipper shared by outline pixels (xs == xe) and fill spans.
// Ports:
//   xs_i, xe_i, y_i : signed centre-relative results (COORD_W+2 bits)
//   xs_c_o, xe_c_o  : span clamped to 0..SCREEN_W-1
//   y_c_o           : row, truncated to COORD_W bits
//   valid_c_o       : row on-screen and span overlaps the visible width
module circle_clip
  import circle_raster_pkg::*;
#(
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
  input  logic signed [COORD_W+1:0] xs_i,
  input  logic signed [COORD_W+1:0] xe_i,
  input  logic signed [COORD_W+1:0] y_i,
  output logic        [COORD_W-1:0] xs_c_o,
  output logic        [COORD_W-1:0] xe_c_o,
  output logic        [COORD_W-1:0] y_c_o,
  output logic                      valid_c_o
);

  localparam int unsigned CW = COORD_W + 2;
  localparam logic signed [CW-1:0] ZERO_S  = '0;
  localparam logic signed [CW-1:0] SW_S    = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] SH_S    = CW'(SCREEN_H);
  localparam logic signed [CW-1:0] XMAX_S  = CW'(SCREEN_W - 1);

  logic signed [CW-1:0] xs_cl;
  logic signed [CW-1:0] xe_cl;

  // Reject off-screen rows and spans entirely left/right of the screen, then clamp.
  always_comb begin
    valid_c_o = (y_i >= ZERO_S) && (y_i < SH_S) && (xe_i >= ZERO_S) && (xs_i < SW_S);
    xs_cl     = (xs_i < ZERO_S) ? ZERO_S : xs_i;
    xe_cl     = (xe_i > XMAX_S) ? XMAX_S : xe_i;
    xs_c_o    = COORD_W'(xs_cl);
    xe_c_o    = COORD_W'(xe_cl);
    y_c_o     = COORD_W'(y_i);
  end

endmodule : circle_clip

// File: rtl/circle_raster.sv
// Midpoint-circle rasteriser. Accepts one circle command over in_rts/in_rtr and
// streams clipped outline pixels or horizontal fill spans over out_rts/out_rtr,
// one element per transfer.
// Ports:
//   clk, rst_                         : clock, async active-low reset
//   x0_in, y0_in, r_in, color_in      : command centre, radius, colour
//   fill_in                           : 0 outline pixels, 1 filled spans
//   in_rts / in_rtr                   : command handshake (in_rtr only in IDLE)
//   out_rts / out_rtr                 : element handshake
//   out_x, out_x_end, out_y, out_color: element payload
//   busy, done                        : status; done pulses once per command
module circle_raster
  import circle_raster_pkg::*;
#(
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned COLOR_W  = 12,
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [COORD_W-1:0] x0_in,
  input  logic [COORD_W-1:0] y0_in,
  input  logic [COORD_W-1:0] r_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               fill_in,
  input  logic               in_rts,
  output logic               in_rtr,
  output logic               out_rts,
  input  logic               out_rtr,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_x_end,
  output logic [COORD_W-1:0] out_y,
  output logic [COLOR_W-1:0] out_color,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CW = COORD_W + 2;
  localparam int unsigned DW = CW + 2;

  state_e               state_q, state_d;
  logic signed [CW-1:0] x_q, x_d, y_q, y_d, dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic signed [CW-1:0] cx0_q, cx0_d, cy0_q, cy0_d;
  logic [COORD_W-1:0]   r_q, r_d;
  logic                 fill_q, fill_d;
  logic [2:0]           idx_q, idx_d;
  logic                 in_rtr_q, in_rtr_d, out_rts_q, out_rts_d, busy_q, busy_d, done_q, done_d;
  logic [COORD_W-1:0]   out_x_q, out_x_d, out_x_end_q, out_x_end_d, out_y_q, out_y_d;
  logic [COLOR_W-1:0]   out_color_q, out_color_d;

  logic signed [CW-1:0] cand_xs, cand_xe, cand_y, r_ext;
  logic                 cand_skip, y_zero, diag, last_idx, advance;
  logic [COORD_W-1:0]   clip_xs, clip_xe, clip_y;
  logic                 clip_valid;
  logic signed [DW-1:0] err_dy, decide;

  assign y_zero   = (y_q == '0);
  assign diag     = (x_q == y_q);
  assign last_idx = (fill_q == MODE_FILL) ? (idx_q == 3'd3) : (idx_q == 3'd7);
  assign r_ext    = CW'(r_q);
  // Midpoint decision 2*(err+dy)+dx, widened so it cannot overflow.
  assign err_dy   = DW'(err_q) + DW'(dy_q);
  assign decide   = err_dy + err_dy + DW'(dx_q);

  // Candidate element for the current idx, plus octant/axis duplicate suppression.
  always_comb begin
    cand_xs   = '0;
    cand_xe   = '0;
    cand_y    = '0;
    cand_skip = 1'b0;
    if (fill_q == MODE_FILL) begin
      case (idx_q[1:0])
        2'd0: begin cand_y = cy0_q + y_q; cand_xs = cx0_q - x_q; cand_xe = cx0_q + x_q; end
        2'd1: begin cand_y = cy0_q - y_q; cand_xs = cx0_q - x_q; cand_xe = cx0_q + x_q;
                    cand_skip = y_zero; end
        2'd2: begin cand_y = cy0_q + x_q; cand_xs = cx0_q - y_q; cand_xe = cx0_q + y_q;
                    cand_skip = diag; end
        2'd3: begin cand_y = cy0_q - x_q; cand_xs = cx0_q - y_q; cand_xe = cx0_q + y_q;
                    cand_skip = diag; end
      endcase
    end else begin
      case (idx_q)
        3'd0: begin cand_xs = cx0_q + x_q; cand_y = cy0_q + y_q; end
        3'd1: begin cand_xs = cx0_q + y_q; cand_y = cy0_q + x_q; cand_skip = diag; end
        3'd2: begin cand_xs = cx0_q - y_q; cand_y = cy0_q + x_q; cand_skip = y_zero; end
        3'd3: begin cand_xs = cx0_q - x_q; cand_y = cy0_q + y_q; cand_skip = diag; end
        3'd4: begin cand_xs = cx0_q - x_q; cand_y = cy0_q - y_q; cand_skip = y_zero; end
        3'd5: begin cand_xs = cx0_q - y_q; cand_y = cy0_q - x_q; cand_skip = diag; end
        3'd6: begin cand_xs = cx0_q + y_q; cand_y = cy0_q - x_q; cand_skip = y_zero; end
        3'd7: begin cand_xs = cx0_q + x_q; cand_y = cy0_q - y_q; cand_skip = y_zero | diag; end
      endcase
      cand_xe = cand_xs;
    end
  end

  circle_clip #(
    .COORD_W  (COORD_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clip (
    .xs_i      (cand_xs),
    .xe_i      (cand_xe),
    .y_i       (cand_y),
    .xs_c_o    (clip_xs),
    .xe_c_o    (clip_xe),
    .y_c_o     (clip_y),
    .valid_c_o (clip_valid)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    err_d       = err_q;
    cx0_d       = cx0_q;
    cy0_d       = cy0_q;
    r_d         = r_q;
    fill_d      = fill_q;
    idx_d       = idx_q;
    out_rts_d   = out_rts_q;
    out_x_d     = out_x_q;
    out_x_end_d = out_x_end_q;
    out_y_d     = out_y_q;
    out_color_d = out_color_q;
    done_d      = 1'b0;
    advance     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_rts && in_rtr_q) begin
          cx0_d       = CW'(x0_in);
          cy0_d       = CW'(y0_in);
          r_d         = r_in;
          fill_d      = fill_in;
          out_color_d = color_in;
          state_d     = INIT;
        end
      end
      INIT: begin
        x_d     = r_ext;
        y_d     = '0;
        dx_d    = CW'(1) - (r_ext + r_ext);
        dy_d    = CW'(1);
        err_d   = '0;
        state_d = CHECK;
      end
      CHECK: begin
        if (x_q >= y_q) begin
          idx_d   = '0;
          state_d = EMIT;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      EMIT: begin
        // Hold a presented element until taken; otherwise evaluate one candidate.
        if (out_rts_q) begin
          if (out_rtr) begin
            out_rts_d = 1'b0;
            advance   = 1'b1;
          end
        end else if (clip_valid && !cand_skip) begin
          out_x_d     = clip_xs;
          out_x_end_d = clip_xe;
          out_y_d     = clip_y;
          out_rts_d   = 1'b1;
        end else begin
          advance = 1'b1;
        end
        if (advance) begin
          if (last_idx) state_d = STEP;
          else          idx_d   = idx_q + 3'd1;
        end
      end
      STEP: begin
        if (!decide[DW-1] && (decide != '0)) begin
          x_d   = x_q - CW'(1);
          err_d = err_q + dx_q;
          dx_d  = dx_q + CW'(2);
        end else begin
          y_d   = y_q + CW'(1);
          err_d = err_q + dy_q;
          dy_d  = dy_q + CW'(2);
        end
        state_d = CHECK;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_rtr_d = (state_d == IDLE);
    busy_d   = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      cx0_q       <= '0;
      cy0_q       <= '0;
      r_q         <= '0;
      fill_q      <= MODE_OUTLINE;
      idx_q       <= '0;
      in_rtr_q    <= 1'b1;
      out_rts_q   <= 1'b0;
      out_x_q     <= '0;
      out_x_end_q <= '0;
      out_y_q     <= '0;
      out_color_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      err_q       <= err_d;
      cx0_q       <= cx0_d;
      cy0_q       <= cy0_d;
      r_q         <= r_d;
      fill_q      <= fill_d;
      idx_q       <= idx_d;
      in_rtr_q    <= in_rtr_d;
      out_rts_q   <= out_rts_d;
      out_x_q     <= out_x_d;
      out_x_end_q <= out_x_end_d;
      out_y_q     <= out_y_d;
      out_color_q <= out_color_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_rtr    = in_rtr_q;
  assign out_rts   = out_rts_q;
  assign out_x     = out_x_q;
  assign out_x_end = out_x_end_q;
  assign out_y     = out_y_q;
  assign out_color = out_color_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule : circle_raster
